// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - instruction memory fetch handshake bundle
//
// Purpose: groups the req/ack fetch bus between fetch_seq and instruction memory.
// Signal names are written from the sequencer's point of view.
//   o_imem_req    sequencer -> memory  fetch request, held until ack
//   o_imem_addr   sequencer -> memory  fetch address (equals PC)
//   i_imem_ack    memory -> sequencer  fetch complete, rdata valid this cycle
//   i_imem_rdata  memory -> sequencer  fetched instruction word
// Modports: master = fetch_seq side, slave = memory side.
interface fetch_seq_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req,
    output o_imem_addr,
    input  i_imem_ack,
    input  i_imem_rdata
  );

  modport slave (
    input  o_imem_req,
    input  o_imem_addr,
    output i_imem_ack,
    output i_imem_rdata
  );
endinterface

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - multi-cycle instruction fetch / next-PC sequencer
//
// Purpose: owns the PC, fetches the word at PC over a req/ack handshake, holds
// it for decode/execute, then selects the next PC (JALR > JAL > taken branch >
// sequential) once execute reports completion. Misaligned targets trap to HALT.
// Optional macro FETCH_SEQ_TIMEOUT_EN adds a fetch wait counter that traps
// with cause 10 after TIMEOUT_CYCLES fetch cycles without ack.
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   imem                  fetch bus (fetch_seq_if.master)
//   o_inst, o_inst_valid  latched instruction and its valid flag
//   o_pc                  PC of o_inst / current fetch
//   i_exec_done           execute finished, next-PC inputs valid
//   i_take_branch, i_branch_offset, i_jal, i_jal_offset, i_jalr, i_jalr_target
//                         next-PC sources
//   o_retired             retired instruction count
//   o_trap, o_trap_cause  halt flag and cause (01 misaligned, 10 timeout)
module fetch_seq #(
  parameter logic [31:0] RESET_ADDR     = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  fetch_seq_if.master        imem,
  output logic [31:0]        o_inst,
  output logic               o_inst_valid,
  output logic [31:0]        o_pc,
  input  logic               i_exec_done,
  input  logic               i_take_branch,
  input  logic [31:0]        i_branch_offset,
  input  logic               i_jal,
  input  logic [31:0]        i_jal_offset,
  input  logic               i_jalr,
  input  logic [31:0]        i_jalr_target,
  output logic [31:0]        o_retired,
  output logic               o_trap,
  output logic [1:0]         o_trap_cause
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_seq: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH      = 2'd1,
    ISSUE      = 2'd2,
    HALT       = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] retired_q;
  logic        req_q;
  logic        valid_q;
  logic        trap_q;
  logic [1:0]  cause_q;
  logic [31:0] next_pc_d;

`ifdef FETCH_SEQ_TIMEOUT_EN
  logic [7:0]  wait_q;
`endif

  // JALR target bit 0 is always cleared, so it is intentionally dropped.
  logic unused_jalr_bit0;
  assign unused_jalr_bit0 = i_jalr_target[0];

  always_comb begin
    next_pc_d = pc_q + 32'd4;
    if (i_jalr) begin
      next_pc_d = {i_jalr_target[31:1], 1'b0};
    end else if (i_jal) begin
      next_pc_d = pc_q + i_jal_offset;
    end else if (i_take_branch) begin
      next_pc_d = pc_q + i_branch_offset;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= FETCH_IDLE;
      pc_q      <= RESET_ADDR;
      inst_q    <= 32'd0;
      retired_q <= 32'd0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      trap_q    <= 1'b0;
      cause_q   <= 2'b00;
`ifdef FETCH_SEQ_TIMEOUT_EN
      wait_q    <= 8'd0;
`endif
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
`ifdef FETCH_SEQ_TIMEOUT_EN
          wait_q  <= 8'd0;
`endif
        end
        FETCH: begin
          if (imem.i_imem_ack) begin
            // Ack wins even on the cycle the timeout limit is reached.
            inst_q  <= imem.i_imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= ISSUE;
          end
`ifdef FETCH_SEQ_TIMEOUT_EN
          else if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
            // wait_q counts prior ack-less cycles; this is the last allowed one.
            trap_q  <= 1'b1;
            cause_q <= 2'b10;
            req_q   <= 1'b0;
            state_q <= HALT;
          end else begin
            wait_q  <= wait_q + 8'd1;
          end
`endif
        end
        ISSUE: begin
          if (i_exec_done) begin
            valid_q <= 1'b0;
            if (next_pc_d[1]) begin
              trap_q  <= 1'b1;
              cause_q <= 2'b01;
              state_q <= HALT;
            end else begin
              pc_q      <= next_pc_d;
              retired_q <= retired_q + 32'd1;
              req_q     <= 1'b1;
              state_q   <= FETCH;
`ifdef FETCH_SEQ_TIMEOUT_EN
              wait_q    <= 8'd0;
`endif
            end
          end
        end
        HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= HALT;
        end
      endcase
    end
  end

  assign imem.o_imem_req  = req_q;
  assign imem.o_imem_addr = pc_q;
  assign o_pc             = pc_q;
  assign o_inst           = inst_q;
  assign o_inst_valid     = valid_q;
  assign o_retired        = retired_q;
  assign o_trap           = trap_q;
  assign o_trap_cause     = cause_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed table-driven bench for fetch_seq
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] o_inst;
  logic        o_inst_valid;
  logic [31:0] o_pc;
  logic        exec_done;
  logic        take_branch;
  logic [31:0] branch_offset;
  logic        jal;
  logic [31:0] jal_offset;
  logic        jalr;
  logic [31:0] jalr_target;
  logic [31:0] o_retired;
  logic        o_trap;
  logic [1:0]  o_trap_cause;

  int total  = 0;
  int passed = 0;
  logic [31:0] exp_ret;

  fetch_seq_if imem_if ();

  always #5 clk = ~clk;

  fetch_seq #(
    .RESET_ADDR     (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .imem            (imem_if.master),
    .o_inst          (o_inst),
    .o_inst_valid    (o_inst_valid),
    .o_pc            (o_pc),
    .i_exec_done     (exec_done),
    .i_take_branch   (take_branch),
    .i_branch_offset (branch_offset),
    .i_jal           (jal),
    .i_jal_offset    (jal_offset),
    .i_jalr          (jalr),
    .i_jalr_target   (jalr_target),
    .o_retired       (o_retired),
    .o_trap          (o_trap),
    .o_trap_cause    (o_trap_cause)
  );

  typedef struct {
    logic [31:0] start_pc;
    logic        tb;
    logic [31:0] boff;
    logic        j;
    logic [31:0] joff;
    logic        jr;
    logic [31:0] jt;
    int          delay;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_if.i_imem_ack = 1'b0;
    imem_if.i_imem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for req, holds off ack for 'delay' cycles, then acks.
  task automatic do_fetch(input int delay, input logic [31:0] word);
    int n;
    logic [31:0] addr0;
    n = 0;
    while (imem_if.o_imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", 32'(imem_if.o_imem_req), 32'd1);
    addr0 = o_pc;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("req_hold", 32'(imem_if.o_imem_req), 32'd1);
      chk("addr_stable", imem_if.o_imem_addr, addr0);
    end
    imem_if.i_imem_ack = 1'b1;
    imem_if.i_imem_rdata = word;
    @(negedge clk);
    imem_if.i_imem_ack = 1'b0;
    imem_if.i_imem_rdata = 32'd0;
    chk("inst_valid", 32'(o_inst_valid), 32'd1);
    chk("inst", o_inst, word);
    chk("req_drop", 32'(imem_if.o_imem_req), 32'd0);
  endtask

  task automatic do_exec(input logic t, input logic [31:0] bo, input logic j,
                         input logic [31:0] jo, input logic jr, input logic [31:0] jt);
    take_branch = t; branch_offset = bo; jal = j; jal_offset = jo;
    jalr = jr; jalr_target = jt; exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0; take_branch = 1'b0; jal = 1'b0; jalr = 1'b0;
    branch_offset = 32'd0; jal_offset = 32'd0; jalr_target = 32'd0;
  endtask

  initial begin
    //                 start        tb    boff           jal   joff           jalr  jt            dly exp
    vecs[0] = '{32'h100,       1'b1, 32'hFFFF_FFF0, 1'b0, 32'd0,         1'b0, 32'd0,        0, 32'h0F0};
    vecs[1] = '{32'h100,       1'b1, 32'hFFFF_FFF0, 1'b1, 32'd8,         1'b0, 32'd0,        1, 32'h108};
    vecs[2] = '{32'h100,       1'b1, 32'h40,        1'b1, 32'd8,         1'b1, 32'h201,      2, 32'h200};
    vecs[3] = '{32'h100,       1'b0, 32'h40,        1'b0, 32'd0,         1'b0, 32'd0,        0, 32'h104};
    vecs[4] = '{32'hFFFF_FFFC, 1'b0, 32'd0,         1'b0, 32'd0,         1'b0, 32'd0,        3, 32'h000};
    vecs[5] = '{32'h10,        1'b0, 32'd0,         1'b1, 32'hFFFF_FFF0, 1'b0, 32'd0,        0, 32'h000};
    vecs[6] = '{32'h200,       1'b1, 32'h1000,      1'b0, 32'd0,         1'b0, 32'd0,        1, 32'h1200};

    exec_done = 1'b0; take_branch = 1'b0; jal = 1'b0; jalr = 1'b0;
    branch_offset = 32'd0; jal_offset = 32'd0; jalr_target = 32'd0;

    // Reset state and FETCH_IDLE cycle
    do_reset();
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_req", 32'(imem_if.o_imem_req), 32'd0);
    chk("rst_valid", 32'(o_inst_valid), 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_retired", o_retired, 32'd0);
    chk("rst_trap", {30'd0, o_trap_cause} | 32'(o_trap), 32'd0);
    @(negedge clk);
    chk("idle_to_fetch_req", 32'(imem_if.o_imem_req), 32'd1);

    // Immediate ack, exec one cycle later: 2 cycles/instruction
    chk("first_addr", imem_if.o_imem_addr, 32'd0);
    do_fetch(0, 32'h0010_0093);
    chk("issue_pc", o_pc, 32'd0);
    do_exec(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    exp_ret = 32'd1;
    chk("seq_pc", o_pc, 32'd4);
    chk("seq_retired", o_retired, exp_ret);
    chk("two_cycle_req", 32'(imem_if.o_imem_req), 32'd1);
    chk("seq_valid_clr", 32'(o_inst_valid), 32'd0);

    // Delayed ack, then spurious ack during ISSUE
    do_fetch(5, 32'hCAFE_0013);
    imem_if.i_imem_ack = 1'b1;
    imem_if.i_imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_if.i_imem_ack = 1'b0;
    chk("spurious_inst", o_inst, 32'hCAFE_0013);
    chk("spurious_req", 32'(imem_if.o_imem_req), 32'd0);
    chk("spurious_valid", 32'(o_inst_valid), 32'd1);
    do_exec(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    exp_ret++;
    chk("delay_pc", o_pc, 32'd8);

    // Next-PC vectors: jalr to start PC, then the vector instruction
    for (int v = 0; v < 7; v++) begin
      do_fetch(0, 32'h0000_0067);
      do_exec(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, vecs[v].start_pc);
      exp_ret++;
      chk($sformatf("v%0d_start", v), o_pc, vecs[v].start_pc);
      do_fetch(vecs[v].delay, 32'h0000_0013 + 32'(v));
      do_exec(vecs[v].tb, vecs[v].boff, vecs[v].j, vecs[v].joff, vecs[v].jr, vecs[v].jt);
      exp_ret++;
      chk($sformatf("v%0d_pc", v), o_pc, vecs[v].exp_pc);
      chk($sformatf("v%0d_retired", v), o_retired, exp_ret);
      chk($sformatf("v%0d_trap", v), 32'(o_trap), 32'd0);
    end

    // Reset during FETCH with ack in the same cycle
    chk("pre_rst_req", 32'(imem_if.o_imem_req), 32'd1);
    rst_n = 1'b0;
    imem_if.i_imem_ack = 1'b1;
    imem_if.i_imem_rdata = 32'h1234_5678;
    @(negedge clk);
    imem_if.i_imem_ack = 1'b0;
    rst_n = 1'b1;
    chk("midrst_pc", o_pc, 32'd0);
    chk("midrst_retired", o_retired, 32'd0);
    chk("midrst_valid", 32'(o_inst_valid), 32'd0);
    chk("midrst_inst", o_inst, 32'd0);
    exp_ret = 32'd0;

    // Misaligned JALR target traps; PC and retired count are held
    do_fetch(0, 32'h0000_0067);
    do_exec(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h200);
    exp_ret++;
    do_fetch(1, 32'h0000_0067);
    do_exec(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h203);
    chk("trap_flag", 32'(o_trap), 32'd1);
    chk("trap_cause", 32'(o_trap_cause), 32'd1);
    chk("trap_pc", o_pc, 32'h200);
    chk("trap_retired", o_retired, exp_ret);
    chk("trap_valid", 32'(o_inst_valid), 32'd0);
    imem_if.i_imem_ack = 1'b1;
    exec_done = 1'b1;
    repeat (3) @(negedge clk);
    imem_if.i_imem_ack = 1'b0;
    exec_done = 1'b0;
    chk("halt_req", 32'(imem_if.o_imem_req), 32'd0);
    chk("halt_trap", 32'(o_trap), 32'd1);
    chk("halt_cause", 32'(o_trap_cause), 32'd1);
    chk("halt_pc", o_pc, 32'h200);

`ifdef FETCH_SEQ_TIMEOUT_EN
    // Never ack: trap after 4 FETCH cycles
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_hold", 32'(imem_if.o_imem_req), 32'd1);
      chk("to_no_trap", 32'(o_trap), 32'd0);
      @(negedge clk);
    end
    chk("to_trap", 32'(o_trap), 32'd1);
    chk("to_cause", 32'(o_trap_cause), 32'd2);
    chk("to_req_drop", 32'(imem_if.o_imem_req), 32'd0);
    // Ack on the 4th FETCH cycle wins
    do_reset();
    @(negedge clk);
    repeat (3) @(negedge clk);
    imem_if.i_imem_ack = 1'b1;
    imem_if.i_imem_rdata = 32'h0000_0093;
    @(negedge clk);
    imem_if.i_imem_ack = 1'b0;
    chk("to_edge_valid", 32'(o_inst_valid), 32'd1);
    chk("to_edge_trap", 32'(o_trap), 32'd0);
`else
    // Without the timeout option the fetch waits indefinitely
    do_reset();
    repeat (40) @(negedge clk);
    chk("nto_req", 32'(imem_if.o_imem_req), 32'd1);
    chk("nto_trap", 32'(o_trap), 32'd0);
    chk("nto_cause", 32'(o_trap_cause), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
